// File: rtl/mc_ctrl.sv
// Multicycle MIPS control unit: IDLE/FETCH/DECODE/EXEC/MEM/WB sequencer with memory wait timeout.
// Optional jal/jr support is enabled by defining MC_CTRL_JAL_EN.
module mc_ctrl #(
  parameter int ALUOP_W = 4,
  parameter int TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               EXTOp,
  output logic               ALUSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         NPCOp,
  output logic [1:0]         GPRSel,
  output logic [1:0]         WDSel,
  output logic [2:0]         state_o,
  output logic               illegal,
  output logic               mem_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ANDI = 6'h0c, OP_ORI = 6'h0d;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] F_JR = 6'h08, F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2a, F_SLTU = 6'h2b;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state, state_n;
  logic [CNT_W-1:0] wait_cnt;

  // 3-bit ALU operation code; 0 marks an opcode/funct with no ALU meaning
  function automatic logic [2:0] alu_code(input logic [5:0] op, input logic [5:0] fn);
    logic [2:0] code;
    code = 3'd0;
    if (op == OP_R) begin
      case (fn)
        F_ADD, F_ADDU: code = 3'd1;
        F_SUB, F_SUBU: code = 3'd2;
        F_AND:         code = 3'd3;
        F_OR:          code = 3'd4;
        F_SLT:         code = 3'd5;
        F_SLTU:        code = 3'd6;
        default:       code = 3'd0;
      endcase
    end else begin
      case (op)
        OP_ADDI, OP_LW, OP_SW: code = 3'd1;
        OP_BEQ:                code = 3'd2;
        OP_ANDI:               code = 3'd3;
        OP_ORI:                code = 3'd4;
        default:               code = 3'd0;
      endcase
    end
    return code;
  endfunction

  logic is_r, r_ok, is_imm, is_lw, is_sw, is_beq, is_j, is_jal, is_jr, legal;
  logic waiting, timeout_hit;

  assign is_r   = (Op == OP_R);
  assign r_ok   = is_r && (alu_code(Op, Funct) != 3'd0);
  assign is_imm = (Op == OP_ADDI) || (Op == OP_ORI) || (Op == OP_ANDI);
  assign is_lw  = (Op == OP_LW);
  assign is_sw  = (Op == OP_SW);
  assign is_beq = (Op == OP_BEQ);
  assign is_j   = (Op == OP_J);
`ifdef MC_CTRL_JAL_EN
  assign is_jal = (Op == OP_JAL);
  assign is_jr  = is_r && (Funct == F_JR);
`else
  assign is_jal = 1'b0;
  assign is_jr  = 1'b0;
`endif
  assign legal = r_ok || is_imm || is_lw || is_sw || is_beq || is_j || is_jal || is_jr;

  // Derived from state directly so the timeout never loops through mem_req
  assign waiting     = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
  assign timeout_hit = (TIMEOUT != 0) && waiting && (wait_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      if ((state_n != state) || !waiting || timeout_hit)
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_n  = state;
    mem_req  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    EXTOp    = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = '0;
    NPCOp    = 2'b00;
    GPRSel   = 2'b00;
    WDSel    = 2'b00;
    illegal  = 1'b0;
    mem_err  = 1'b0;
    if ((state == S_EXEC) || (state == S_MEM) || (state == S_WB)) begin
      ALUOp  = ALUOP_W'(alu_code(Op, Funct));
      ALUSrc = is_imm || is_lw || is_sw;
      EXTOp  = (Op == OP_ADDI) || is_lw || is_sw;
    end
    case (state)
      S_IDLE: state_n = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_n = S_DECODE;
        end else if (timeout_hit) begin
          mem_err = 1'b1;
        end
      end
      S_DECODE: begin
        state_n = S_FETCH;
        if (is_j) begin
          PCWrite = 1'b1;
          NPCOp   = 2'b10;
        end else if (is_jal) begin
          PCWrite  = 1'b1;
          NPCOp    = 2'b10;
          RegWrite = 1'b1;
          GPRSel   = 2'b10;
          WDSel    = 2'b10;
        end else if (is_jr) begin
          PCWrite = 1'b1;
          NPCOp   = 2'b11;
        end else if (!legal) begin
          illegal = 1'b1;
        end else begin
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq) begin
          PCWrite = Zero;
          NPCOp   = 2'b01;
          state_n = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_n = S_MEM;
        end else begin
          state_n = S_WB;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        MemRead  = is_lw;
        MemWrite = is_sw;
        if (mem_ready) begin
          state_n = is_lw ? S_WB : S_FETCH;
        end else if (timeout_hit) begin
          mem_err = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        GPRSel   = is_r ? 2'b00 : 2'b01;
        WDSel    = is_lw ? 2'b01 : 2'b00;
        state_n  = S_FETCH;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction expected cycle traces built from the
// instruction semantics, replayed against the DUT with randomized instructions and waits.
module tb_mc_ctrl;
  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [5:0] Op = 6'h00, Funct = 6'h20;
  logic       Zero = 1'b0, mem_ready = 1'b1;
  logic       mem_req, MemRead, MemWrite, PCWrite, IRWrite, RegWrite, EXTOp, ALUSrc;
  logic [3:0] ALUOp;
  logic [1:0] NPCOp, GPRSel, WDSel;
  logic [2:0] state_o;
  logic       illegal, mem_err;

  mc_ctrl #(.ALUOP_W(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .EXTOp(EXTOp), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .NPCOp(NPCOp), .GPRSel(GPRSel), .WDSel(WDSel), .state_o(state_o), .illegal(illegal),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rdy;
    logic       zero;
    logic [5:0] op;
    logic [5:0] fn;
    logic [2:0] st;
    logic       mreq, mrd, mwr, pcw, irw, rgw, ext, asrc;
    logic [3:0] aluop;
    logic [1:0] npc, gsel, wdsel;
    logic       ill, merr;
  } cyc_t;

  typedef enum logic [3:0] {K_R, K_IMM, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_ILL} kind_t;

  cyc_t       q[$];
  int         obs_st[$];
  int         n_rd, n_merr, n_rgw;
  int         n_chk = 0, n_err = 0;
  logic [5:0] cur_op, cur_fn;

  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h2b}) return K_R;
`ifdef MC_CTRL_JAL_EN
      if (fn == 6'h08) return K_JR;
`endif
      return K_ILL;
    end
    case (op)
      6'h08, 6'h0c, 6'h0d: return K_IMM;
      6'h23:               return K_LW;
      6'h2b:               return K_SW;
      6'h04:               return K_BEQ;
      6'h02:               return K_J;
`ifdef MC_CTRL_JAL_EN
      6'h03:               return K_JAL;
`endif
      default:             return K_ILL;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: return 4'd1;
        6'h22, 6'h23: return 4'd2;
        6'h24:        return 4'd3;
        6'h25:        return 4'd4;
        6'h2a:        return 4'd5;
        6'h2b:        return 4'd6;
        default:      return 4'd0;
      endcase
    end
    case (op)
      6'h08, 6'h23, 6'h2b: return 4'd1;
      6'h04:               return 4'd2;
      6'h0c:               return 4'd3;
      6'h0d:               return 4'd4;
      default:             return 4'd0;
    endcase
  endfunction

  function automatic cyc_t blank(input logic [2:0] st);
    cyc_t c;
    c      = '0;
    c.st   = st;
    c.op   = cur_op;
    c.fn   = cur_fn;
    c.rdy  = 1'($urandom);
    c.zero = 1'($urandom);
    return c;
  endfunction

  function automatic cyc_t alu_fields(input cyc_t c_in, input kind_t k);
    cyc_t c;
    c       = c_in;
    c.aluop = alu_of(cur_op, cur_fn);
    c.asrc  = (k == K_IMM) || (k == K_LW) || (k == K_SW);
    c.ext   = (k == K_LW) || (k == K_SW) || (cur_op == 6'h08);
    return c;
  endfunction

  // Expected trace of one instruction: fw fetch wait cycles, mw data wait cycles
  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fw, input int mw);
    cyc_t  c;
    kind_t k;
    cur_op = op;
    cur_fn = fn;
    k = classify(op, fn);
    for (int i = 1; i <= fw; i++) begin
      c = blank(3'd1); c.rdy = 1'b0; c.mreq = 1'b1; c.merr = (i % TMO == 0);
      q.push_back(c);
    end
    c = blank(3'd1); c.rdy = 1'b1; c.mreq = 1'b1; c.irw = 1'b1; c.pcw = 1'b1;
    q.push_back(c);
    c = blank(3'd2);
    case (k)
      K_J:   begin c.pcw = 1'b1; c.npc = 2'b10; end
      K_JAL: begin c.pcw = 1'b1; c.npc = 2'b10; c.rgw = 1'b1; c.gsel = 2'b10; c.wdsel = 2'b10; end
      K_JR:  begin c.pcw = 1'b1; c.npc = 2'b11; end
      K_ILL: c.ill = 1'b1;
      default: ;
    endcase
    q.push_back(c);
    if (k inside {K_J, K_JAL, K_JR, K_ILL}) return;
    c = alu_fields(blank(3'd3), k);
    if (k == K_BEQ) begin
      c.zero = z; c.pcw = z; c.npc = 2'b01;
      q.push_back(c);
      return;
    end
    q.push_back(c);
    if (k == K_LW || k == K_SW) begin
      for (int i = 1; i <= mw && i <= TMO; i++) begin
        c = alu_fields(blank(3'd4), k);
        c.rdy = 1'b0; c.mreq = 1'b1; c.mrd = (k == K_LW); c.mwr = (k == K_SW);
        c.merr = (i == TMO);
        q.push_back(c);
      end
      if (mw >= TMO) return;
      c = alu_fields(blank(3'd4), k);
      c.rdy = 1'b1; c.mreq = 1'b1; c.mrd = (k == K_LW); c.mwr = (k == K_SW);
      q.push_back(c);
      if (k == K_SW) return;
    end
    c = alu_fields(blank(3'd5), k);
    c.rgw = 1'b1; c.gsel = (k == K_R) ? 2'b00 : 2'b01; c.wdsel = (k == K_LW) ? 2'b01 : 2'b00;
    q.push_back(c);
  endtask

  function automatic logic [22:0] exp_vec(input cyc_t c);
    return {c.st, c.mreq, c.mrd, c.mwr, c.pcw, c.irw, c.rgw, c.ext, c.asrc, c.aluop,
            c.npc, c.gsel, c.wdsel, c.ill, c.merr};
  endfunction

  task automatic check(input cyc_t e, input string tag);
    logic [22:0] got, want;
    got  = {state_o, mem_req, MemRead, MemWrite, PCWrite, IRWrite, RegWrite, EXTOp, ALUSrc,
            ALUOp, NPCOp, GPRSel, WDSel, illegal, mem_err};
    want = exp_vec(e);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s t=%0t op=%h fn=%h got=%h expected=%h", tag, $time, e.op, e.fn, got, want);
    end
  endtask

  task automatic lit(input string tag, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic run_q(input string tag);
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      mem_ready = c.rdy; Zero = c.zero; Op = c.op; Funct = c.fn;
      #1;
      check(c, tag);
      obs_st.push_back(int'(state_o));
      n_rd   += int'(MemRead);
      n_merr += int'(mem_err);
      n_rgw  += int'(RegWrite);
    end
  endtask

  task automatic clear_obs();
    obs_st.delete();
    n_rd = 0; n_merr = 0; n_rgw = 0;
  endtask

  // With rstn low: check outputs, release, check IDLE; the next edge enters FETCH
  task automatic reset_release();
    @(negedge clk);
    mem_ready = 1'b1; Op = 6'h23; Funct = 6'h20;
    #1;
    check(blank(3'd0), "reset_hold");
    rstn = 1'b1;
    #1;
    check(blank(3'd0), "idle_after_release");
  endtask

  logic [5:0] ops[19] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                          6'h08, 6'h0d, 6'h0c, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03,
                          6'h00, 6'h3f, 6'h00};
  logic [5:0] fns[19] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h2b,
                          6'h15, 6'h00, 6'h3f, 6'h11, 6'h02, 6'h20, 6'h00, 6'h00,
                          6'h08, 6'h00, 6'h07};
  int exp_add[4] = '{1, 2, 3, 5};

  initial begin
    cur_op = 6'h00; cur_fn = 6'h20;
    repeat (2) @(posedge clk);
    reset_release();

    // add, zero-wait memory
    clear_obs();
    push_instr(6'h00, 6'h20, 1'b0, 0, 0);
    lit("cpi_add", q.size(), 4);
    run_q("add");
    lit("add_len", obs_st.size(), 4);
    for (int i = 0; i < 4 && i < obs_st.size(); i++) lit("add_state_seq", obs_st[i], exp_add[i]);
    lit("add_regwrite_cycles", n_rgw, 1);

    // lw with three data wait cycles
    clear_obs();
    push_instr(6'h23, 6'h00, 1'b0, 0, 3);
    lit("cpi_lw_wait3", q.size(), 8);
    run_q("lw_wait3");
    lit("lw_memread_cycles", n_rd, 4);

    // beq taken and not taken
    push_instr(6'h04, 6'h00, 1'b1, 0, 0);
    lit("cpi_beq", q.size(), 3);
    run_q("beq_taken");
    push_instr(6'h04, 6'h00, 1'b0, 0, 0);
    run_q("beq_not_taken");

    // sw whose data request times out
    clear_obs();
    push_instr(6'h2b, 6'h00, 1'b0, 0, 9);
    lit("cpi_sw_timeout", q.size(), 7);
    run_q("sw_timeout");
    lit("sw_timeout_mem_err", n_merr, 1);
    lit("sw_timeout_regwrite", n_rgw, 0);

    // fetch timeout, illegal opcode, j, jal
    clear_obs();
    push_instr(6'h02, 6'h00, 1'b0, 5, 0);
    run_q("j_fetch_timeout");
    lit("fetch_timeout_mem_err", n_merr, 1);
    push_instr(6'h3f, 6'h00, 1'b0, 0, 0);
    lit("cpi_illegal", q.size(), 2);
    run_q("illegal");
    push_instr(6'h03, 6'h00, 1'b0, 0, 0);
    run_q("jal");

    // reset asserted while a sw sits in MEM
    push_instr(6'h2b, 6'h00, 1'b0, 0, 0);
    run_q("sw_before_reset");
    #1 rstn = 1'b0;
    #1 check(blank(3'd0), "async_reset_in_mem");
    reset_release();

    // randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      int idx, fw, mw;
      idx = int'($urandom_range(0, 18));
      fw  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      mw  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
      push_instr(ops[idx], fns[idx], 1'($urandom), fw, mw);
      run_q("random");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
